// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 32-bit words and writes them to imem.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned BASE_ADDR = 4,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [31:0] LAST = 32'(MEM_DEPTH - 1);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      count         <= '0;
      byte_idx      <= '0;
      word          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= HDR_HI;
            in_ready      <= 1'b1;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            wr_addr       <= BASE;
            byte_idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end
        HDR_HI: begin
          if (in_valid) begin
            count[15:8] <= in_data;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (in_valid) begin
            count[7:0] <= in_data;
            if ({count[15:8], in_data} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state    <= DATA;
              byte_idx <= '0;
            end
          end
        end
        DATA: begin
          if (in_valid) begin
            word     <= {word[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              // bound check decided here so the strobe lands in WRITE
              if (wr_addr <= LAST) begin
                wr_en   <= 1'b1;
                wr_data <= {word, in_data};
              end
            end
          end
        end
        WRITE: begin
          if (wr_en) begin
            wr_addr       <= wr_addr + STEP;
            words_written <= words_written + 16'd1;
            count         <= count - 16'd1;
            if (count == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
              in_ready <= 1'b1;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state    <= DATA;
              in_ready <= 1'b1;
            end
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
